// File: rtl/mem_stage_mq_if.sv
// Execute -> memory -> writeback pipeline signals plus the data-SRAM response
// channel and writeback flush, as seen by the memory stage.
interface mem_stage_mq_if #(
  parameter int CNT_W = 3
);
  logic              es_to_ms_valid;
  logic              ms_allowin;
  logic              es_req;
  logic [6:0]        es_ld_op;
  logic              es_res_from_mem;
  logic              es_gr_we;
  logic [4:0]        es_dest;
  logic [31:0]       es_alu_result;
  logic              es_ex;
  logic [31:0]       es_pc;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              flush;
  logic              ws_allowin;
  logic              ms_to_ws_valid;
  logic [31:0]       ms_pc;
  logic [31:0]       ms_final_result;
  logic [4:0]        ms_dest;
  logic [3:0]        ms_rf_we;
  logic              ms_ex;
  logic [CNT_W-1:0]  ms_inflight;

  modport master (
    output es_to_ms_valid, es_req, es_ld_op, es_res_from_mem, es_gr_we,
           es_dest, es_alu_result, es_ex, es_pc,
           data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_final_result, ms_dest,
           ms_rf_we, ms_ex, ms_inflight
  );

  modport slave (
    input  es_to_ms_valid, es_req, es_ld_op, es_res_from_mem, es_gr_we,
           es_dest, es_alu_result, es_ex, es_pc,
           data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_final_result, ms_dest,
           ms_rf_we, ms_ex, ms_inflight
  );
endinterface

// File: rtl/mem_stage_mq.sv
// Memory stage holding up to DEPTH loads/stores in flight: in-order instruction
// queue, in-order read-data FIFO, and a discard counter for flushed responses.
module mem_stage_mq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic           clk,
  input logic           reset,
  mem_stage_mq_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic        req;
    logic [6:0]  ld_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic        ex;
    logic [31:0] pc;
  } entry_t;

  entry_t           q_mem  [DEPTH];
  logic [31:0]      rd_mem [DEPTH];
  logic [PTR_W-1:0] q_head, q_tail, rd_head, rd_tail;
  logic [CNT_W-1:0] q_count, rd_count, discard_cnt, inflight, inflight_next;
  logic [CNT_W:0]   occupancy;

  entry_t      head, entry_in;
  logic        allowin, valid, push, pop, rd_push, rd_pop, issue;
  logic        rd_empty, discard_zero, bypass, head_ready;
  logic [1:0]  p;
  logic [31:0] d, load_res;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign entry_in = '{req: bus.es_req, ld_op: bus.es_ld_op,
                      res_from_mem: bus.es_res_from_mem, gr_we: bus.es_gr_we,
                      dest: bus.es_dest, alu_result: bus.es_alu_result,
                      ex: bus.es_ex, pc: bus.es_pc};

  // Queued entries plus pending discards bound the responses memory may still owe.
  assign occupancy    = {1'b0, q_count} + {1'b0, discard_cnt};
  assign allowin      = occupancy < (CNT_W+1)'(DEPTH);
  assign push         = bus.es_to_ms_valid && allowin && !bus.flush;

  assign head         = q_mem[q_head];
  assign rd_empty     = (rd_count == '0);
  assign discard_zero = (discard_cnt == '0);
  assign bypass       = rd_empty && bus.data_sram_data_ok && discard_zero;
  assign head_ready   = !head.req || head.ex || !rd_empty || bypass;
  assign valid        = (q_count != '0) && head_ready && !bus.flush;
  assign pop          = valid && bus.ws_allowin;
  assign rd_pop       = pop && head.req && !rd_empty;
  // A response consumed through the bypass path never lands in the FIFO.
  assign rd_push      = bus.data_sram_data_ok && discard_zero && !bus.flush &&
                        !(pop && head.req && rd_empty);

  // Requests offered in the flush cycle were still accepted by memory.
  assign issue         = bus.flush ? (bus.es_to_ms_valid && bus.es_req) : (push && bus.es_req);
  assign inflight_next = inflight + CNT_W'(issue) - CNT_W'(bus.data_sram_data_ok);

  always_comb begin
    p        = head.alu_result[1:0];
    d        = rd_empty ? bus.data_sram_rdata : rd_mem[rd_head];
    byte_sel = d[7:0];
    case (p)
      2'd0: byte_sel = d[7:0];
      2'd1: byte_sel = d[15:8];
      2'd2: byte_sel = d[23:16];
      2'd3: byte_sel = d[31:24];
      default: byte_sel = d[7:0];
    endcase
    half_sel = (p == 2'd0) ? d[15:0] : d[31:16];
    load_res = d;
    if (head.ld_op[5])      load_res = {{24{byte_sel[7]}}, byte_sel};
    else if (head.ld_op[4]) load_res = {24'b0, byte_sel};
    else if (head.ld_op[3]) load_res = {{16{half_sel[15]}}, half_sel};
    else if (head.ld_op[2]) load_res = {16'b0, half_sel};
    else if (head.ld_op[1]) load_res = d << {~p, 3'b000};
    else if (head.ld_op[0]) load_res = d >> {p, 3'b000};
  end

  always_comb begin
    bus.ms_rf_we = '0;
    if (valid) begin
      if (head.ld_op[1])      bus.ms_rf_we = {1'b1, p != 2'd0, p[1], p == 2'd3};
      else if (head.ld_op[0]) bus.ms_rf_we = {p == 2'd0, !p[1], p != 2'd3, 1'b1};
      else                    bus.ms_rf_we = {4{head.gr_we}};
    end
  end

  assign bus.ms_allowin      = allowin;
  assign bus.ms_to_ws_valid  = valid;
  assign bus.ms_pc           = head.pc;
  assign bus.ms_dest         = head.dest;
  assign bus.ms_ex           = valid && head.ex;
  assign bus.ms_final_result = head.res_from_mem ? load_res : head.alu_result;
  assign bus.ms_inflight     = inflight;

  always_ff @(posedge clk) begin
    if (push)    q_mem[q_tail]   <= entry_in;
    if (rd_push) rd_mem[rd_tail] <= bus.data_sram_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_head      <= '0;
      q_tail      <= '0;
      q_count     <= '0;
      rd_head     <= '0;
      rd_tail     <= '0;
      rd_count    <= '0;
      discard_cnt <= '0;
      inflight    <= '0;
    end else if (bus.flush) begin
      q_head      <= '0;
      q_tail      <= '0;
      q_count     <= '0;
      rd_head     <= '0;
      rd_tail     <= '0;
      rd_count    <= '0;
      discard_cnt <= inflight_next;
      inflight    <= inflight_next;
    end else begin
      if (push)   q_tail  <= q_tail + PTR_W'(1);
      if (pop)    q_head  <= q_head + PTR_W'(1);
      if (rd_push) rd_tail <= rd_tail + PTR_W'(1);
      if (rd_pop)  rd_head <= rd_head + PTR_W'(1);
      q_count  <= q_count + CNT_W'(push) - CNT_W'(pop);
      rd_count <= rd_count + CNT_W'(rd_push) - CNT_W'(rd_pop);
      if (bus.data_sram_data_ok && !discard_zero) discard_cnt <= discard_cnt - CNT_W'(1);
      inflight <= inflight_next;
    end
  end
endmodule
